gate_sweep_ctrl: RTL and testbench
==================================

Name: gate_sweep_ctrl

Overview:
Self-test sequencer for the two-input gate bank. It drives operands a/b through all four combinations (00, 10, 01, 11) and holds the bank enabled while each settles. It captures the bank's 8-bit output for every combination and compares each capture against the internal golden truth table. Sits beside the gate bank in the top-level wrapper; the result is readable on user IO.

Parameters:
SETTLE_CYCLES, 1, cycles operands are held before sampling; legal range 1..15, other values illegal.
CNT_W, 4, width of settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin sweep; sampled only in IDLE.
gate_en  output  1  enable to gate bank.
op_a  output  1  operand a to gate bank.
op_b  output  1  operand b to gate bank.
gate_out  input  8  gate bank outputs.
busy  output  1  high in DRIVE and SAMPLE.
done  output  1  one-cycle pulse when sweep completes.
pass  output  1  1 when all 32 captured bits matched golden; valid from done onward.
fail_mask  output  8  OR over all combinations of per-bit mismatches.
result  output  32  captures; byte k = combination index k.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, idx=0, cnt=0, gate_en=0, op_a=0, op_b=0, busy=0, done=0, pass=0, fail_mask=0, result=0.
- Operand mapping: idx is 2 bits; op_a=idx[0], op_b=idx[1].
- Golden bytes by idx: 0→0x78, 1→0x0E, 2→0xCE, 3→0xA3. Bit meanings: bit0 AND, bit1 OR, bit2 XOR, bit3 NAND, bit4 NOR, bit5 XNOR, bit6 NOT a, bit7 b.
- IDLE: gate_en=0, busy=0. If start=1: go to DRIVE with idx=0, cnt=0, fail_mask=0, result=0, pass=0.
- DRIVE: gate_en=1, busy=1. cnt increments each cycle; when cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (1 cycle): gate_en=1. On the exiting edge:
  - result[8*idx+:8] <= gate_out.
  - fail_mask <= fail_mask | (gate_out ^ golden[idx]).
  - If idx==3, go to DONE; else idx <= idx+1, cnt <= 0, go to DRIVE.
- DONE (1 cycle): done=1, busy=0, gate_en=0. pass = (final fail_mask==0), using the SAMPLE-updated mask. Next state IDLE.
- Hold after completion: pass, fail_mask and result hold until the next accepted start clears them.
- Latency: each combination occupies SETTLE_CYCLES+1 cycles. done is asserted in the cycle 4*(SETTLE_CYCLES+1)+1 after the edge that sampled start.
- Operand timing: op_a/op_b change only on DRIVE entry and stay stable through SAMPLE.
- start outside IDLE (busy or DONE) is ignored; there is no queuing or restart.
- start held high continuously: a new sweep begins in the cycle after DONE.
- rst mid-sweep: all registers return to reset values on the next edge; the partial result is discarded and there is no done pulse.
- X on gate_out is not handled; the bench must drive known values.

Test Plan:
- SETTLE_CYCLES=1, ideal gate model, 1-cycle start pulse → done high exactly 9 cycles after the start edge; result=0xA3CE0E78, fail_mask=0x00, pass=1.
- Observe operands during the same sweep → (op_a,op_b) sequence 00,10,01,11, each held 2 cycles; gate_en high 8 cycles, then low in DONE.
- Fault model: bit2 (XOR) stuck-at-0 → result=0xA3CA0A78, fail_mask=0x04, pass=0.
- SETTLE_CYCLES=3, start pulses repeated while busy → single sweep; done 17 cycles after the first start; no second sweep.
- rst asserted on the 5th cycle of a sweep → next cycle all outputs at reset values, no done. A new start then gives a clean pass sweep.
- start held high for 30 cycles (SETTLE=1) → sweeps back-to-back with 1 IDLE cycle between; done pulses at cycles 9, 19, 29; results cleared at each restart.

Source files
------------

// File: rtl/gate_sweep_if.sv
// Bundles the sequencer's start/result signals and the gate-bank operand/capture path.
// Strict valid/ready does not apply here: start is a level sampled only while idle, done is a 1-cycle pulse.
interface gate_sweep_if;
  logic        start;
  logic        gate_en;
  logic        op_a;
  logic        op_b;
  logic [7:0]  gate_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  fail_mask;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  modport master (
    input  start, gate_out,
    output gate_en, op_a, op_b, busy, done, pass, fail_mask, result, state_dbg
  );

  modport slave (
    output start, gate_out,
    input  gate_en, op_a, op_b, busy, done, pass, fail_mask, result, state_dbg
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: walks operands through 00,10,01,11, captures the gate bank byte
// for each and accumulates mismatches against the golden truth table.
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input logic          clk,
  input logic          rst,
  gate_sweep_if.master bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t          state, state_nx;
  logic [1:0]      idx, idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic            gate_en, gate_en_nx;
  logic            op_a, op_a_nx;
  logic            op_b, op_b_nx;
  logic            busy, busy_nx;
  logic            done, done_nx;
  logic            pass, pass_nx;
  logic [7:0]      fail_mask, fail_mask_nx;
  logic [31:0]     result, result_nx;

  // bit0 AND, bit1 OR, bit2 XOR, bit3 NAND, bit4 NOR, bit5 XNOR, bit6 NOT a, bit7 b
  function automatic logic [7:0] golden(input logic [1:0] i);
    case (i)
      2'd0:    golden = 8'h78;
      2'd1:    golden = 8'h0E;
      2'd2:    golden = 8'hCE;
      default: golden = 8'hA3;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      gate_en   <= 1'b0;
      op_a      <= 1'b0;
      op_b      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 8'h00;
      result    <= 32'h0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      gate_en   <= gate_en_nx;
      op_a      <= op_a_nx;
      op_b      <= op_b_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      fail_mask <= fail_mask_nx;
      result    <= result_nx;
    end
  end

  // Outputs are registered, so each branch sets them for the state being entered.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    cnt_nx       = cnt;
    gate_en_nx   = gate_en;
    op_a_nx      = op_a;
    op_b_nx      = op_b;
    busy_nx      = busy;
    done_nx      = 1'b0;
    pass_nx      = pass;
    fail_mask_nx = fail_mask;
    result_nx    = result;
    case (state)
      IDLE: begin
        gate_en_nx = 1'b0;
        busy_nx    = 1'b0;
        if (bus.start) begin
          state_nx     = DRIVE;
          idx_nx       = 2'd0;
          cnt_nx       = '0;
          fail_mask_nx = 8'h00;
          result_nx    = 32'h0;
          pass_nx      = 1'b0;
          gate_en_nx   = 1'b1;
          busy_nx      = 1'b1;
          op_a_nx      = 1'b0;
          op_b_nx      = 1'b0;
        end
      end
      DRIVE: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nx = SAMPLE;
        end
      end
      SAMPLE: begin
        result_nx[{idx, 3'b000} +: 8] = bus.gate_out;
        fail_mask_nx = fail_mask | (bus.gate_out ^ golden(idx));
        if (idx == 2'd3) begin
          state_nx   = DONE;
          done_nx    = 1'b1;
          busy_nx    = 1'b0;
          gate_en_nx = 1'b0;
          pass_nx    = (fail_mask_nx == 8'h00);
        end else begin
          state_nx = DRIVE;
          idx_nx   = idx + 2'd1;
          cnt_nx   = '0;
          op_a_nx  = idx_nx[0];
          op_b_nx  = idx_nx[1];
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.gate_en   = gate_en;
  assign bus.op_a      = op_a;
  assign bus.op_b      = op_b;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.fail_mask = fail_mask;
  assign bus.result    = result;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (settle 1 and 3) driven by a gate-bank model,
// checked every cycle against a sweep-timeline model plus hand-computed literals.
module tb_gate_sweep_ctrl;

  logic clk;
  logic rst;
  logic fault_a;
  logic fault_b;
  int   n_cmp;
  int   n_bad;

  gate_sweep_if if_a ();
  gate_sweep_if if_b ();

  gate_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  gate_sweep_ctrl #(.SETTLE_CYCLES(3), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- gate bank model ----------------
  function automatic logic [7:0] gm(input logic a, input logic b);
    return {b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
  endfunction

  // Fault option: XOR output (bit2) stuck at 0
  assign if_a.gate_out = gm(if_a.op_a, if_a.op_b) & ~(fault_a ? 8'h04 : 8'h00);
  assign if_b.gate_out = gm(if_b.op_a, if_b.op_b) & ~(fault_b ? 8'h04 : 8'h00);

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // k = cycles since the edge that accepted start (0 = not sweeping). A sweep of
  // settle S lasts 4*(S+1) busy cycles plus one done cycle.
  int          mk[2];
  logic [31:0] mres[2];
  logic [7:0]  mmask[2];
  logic        mpass[2];
  int          mcombo[2];
  bit          m_valid;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int s;
      int len;
      int n;
      logic st;
      logic flt;
      logic [7:0] lb;
      s   = settle_of(i);
      len = 4 * (s + 1) + 1;
      st  = (i == 0) ? if_a.start : if_b.start;
      flt = (i == 0) ? fault_a : fault_b;
      if (rst) begin
        mk[i] = 0; mres[i] = 32'h0; mmask[i] = 8'h00; mpass[i] = 1'b0; mcombo[i] = 0;
        m_valid = 1'b1;
      end else if (mk[i] == 0) begin
        if (st) begin
          mk[i] = 1; mres[i] = 32'h0; mmask[i] = 8'h00; mpass[i] = 1'b0;
        end
      end else if (mk[i] == len) begin
        mk[i] = 0;
      end else begin
        mk[i] = mk[i] + 1;
      end
      if (mk[i] > 0) begin
        n = (mk[i] - 1) / (s + 1);
        if (n > 4) n = 4;
        mres[i]  = 32'h0;
        mmask[i] = 8'h00;
        for (int c = 0; c < n; c++) begin
          lb = gm(c[0], c[1]) & ~(flt ? 8'h04 : 8'h00);
          mres[i][8*c +: 8] = lb;
          mmask[i] = mmask[i] | (lb ^ gm(c[0], c[1]));
        end
        mcombo[i] = (n > 3) ? 3 : n;
        mpass[i]  = (mk[i] == len) && (mmask[i] == 8'h00);
      end
    end
  end

  task automatic cmp_inst(input string nm, input int i, input logic gate_en, input logic op_a,
                          input logic op_b, input logic busy, input logic done, input logic pass,
                          input logic [7:0] fm, input logic [31:0] res);
    int  len;
    logic act;
    len = 4 * (settle_of(i) + 1) + 1;
    act = (mk[i] >= 1) && (mk[i] < len);
    chk({nm, "_gate_en"},   32'(gate_en), 32'(act));
    chk({nm, "_busy"},      32'(busy),    32'(act));
    chk({nm, "_done"},      32'(done),    32'(mk[i] == len));
    chk({nm, "_op_a"},      32'(op_a),    32'(mcombo[i] & 1));
    chk({nm, "_op_b"},      32'(op_b),    32'((mcombo[i] >> 1) & 1));
    chk({nm, "_pass"},      32'(pass),    32'(mpass[i]));
    chk({nm, "_fail_mask"}, 32'(fm),      32'(mmask[i]));
    chk({nm, "_result"},    res,          mres[i]);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp_inst("a", 0, if_a.gate_en, if_a.op_a, if_a.op_b, if_a.busy, if_a.done, if_a.pass,
               if_a.fail_mask, if_a.result);
      cmp_inst("b", 1, if_b.gate_en, if_b.op_a, if_b.op_b, if_b.busy, if_b.done, if_b.pass,
               if_b.fail_mask, if_b.result);
    end
  end

  // ---------------- driver tasks ----------------
  // One start pulse on instance a; returns at the negedge of the done cycle (or after the bound).
  task automatic run_sweep_a(output int lat, output logic [15:0] ops, output int gen);
    lat = 0;
    ops = 16'h0;
    gen = 0;
    @(negedge clk);
    if_a.start = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) if_a.start = 1'b0;
      if (j <= 8) ops[2*(j-1) +: 2] = {if_a.op_b, if_a.op_a};
      if (if_a.gate_en) gen++;
      if (if_a.done) begin
        lat = j;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int gen;
    int dcnt;
    int dlat[3];
    logic [15:0] ops;

    n_cmp = 0;
    n_bad = 0;
    m_valid = 1'b0;
    rst = 1'b1;
    fault_a = 1'b0;
    fault_b = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_result", if_a.result, 32'h0);
    chk("rst_busy", 32'(if_a.busy), 32'h0);
    chk("rst_state_a", 32'(if_a.state_dbg), 32'h0);
    chk("rst_state_b", 32'(if_b.state_dbg), 32'h0);
    repeat (2) @(negedge clk);

    // ideal sweep, settle 1
    run_sweep_a(lat, ops, gen);
    chk("ideal_done_lat", 32'(lat), 32'd9);
    chk("ideal_ops_seq", 32'(ops), 32'h0000_FA50);
    chk("ideal_gate_en_cycles", 32'(gen), 32'd8);
    chk("ideal_result", if_a.result, 32'hA3CE0E78);
    chk("ideal_fail_mask", 32'(if_a.fail_mask), 32'h0);
    chk("ideal_pass", 32'(if_a.pass), 32'h1);
    repeat (3) @(negedge clk);

    // XOR stuck-at-0
    fault_a = 1'b1;
    run_sweep_a(lat, ops, gen);
    chk("fault_done_lat", 32'(lat), 32'd9);
    chk("fault_result", if_a.result, 32'hA3CA0A78);
    chk("fault_fail_mask", 32'(if_a.fail_mask), 32'h04);
    chk("fault_pass", 32'(if_a.pass), 32'h0);
    repeat (2) @(negedge clk);
    fault_a = 1'b0;
    repeat (2) @(negedge clk);

    // settle 3, start re-pulsed while busy and during done
    if_b.start = 1'b1;
    dcnt = 0;
    lat = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if_b.start = (j == 3 || j == 8 || j == 17);
      if (if_b.done) begin
        dcnt++;
        if (lat == 0) lat = j;
      end
    end
    if_b.start = 1'b0;
    chk("b_done_lat", 32'(lat), 32'd17);
    chk("b_done_count", 32'(dcnt), 32'd1);
    chk("b_result", if_b.result, 32'hA3CE0E78);
    repeat (2) @(negedge clk);

    // reset on the 5th cycle of a sweep
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_result", if_a.result, 32'h0);
    chk("midrst_busy", 32'(if_a.busy), 32'h0);
    chk("midrst_done", 32'(if_a.done), 32'h0);
    chk("midrst_op_a", 32'(if_a.op_a), 32'h0);
    repeat (2) @(negedge clk);
    run_sweep_a(lat, ops, gen);
    chk("post_rst_done_lat", 32'(lat), 32'd9);
    chk("post_rst_result", if_a.result, 32'hA3CE0E78);
    chk("post_rst_pass", 32'(if_a.pass), 32'h1);
    repeat (3) @(negedge clk);

    // start held high for 30 cycles
    if_a.start = 1'b1;
    dcnt = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (if_a.done) begin
        if (dcnt < 3) dlat[dcnt] = j;
        dcnt++;
      end
    end
    if_a.start = 1'b0;
    chk("held_done_count", 32'(dcnt), 32'd3);
    chk("held_done0", 32'(dlat[0]), 32'd9);
    chk("held_done1", 32'(dlat[1]), 32'd19);
    chk("held_done2", 32'(dlat[2]), 32'd29);
    repeat (12) @(negedge clk);
    chk("held_no_restart_busy", 32'(if_a.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
